// File: rtl/riscv_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : riscv_div_unit
// Purpose  : Multi-cycle restoring shift-subtract divider implementing RV32M
//            DIV, DIVU, REM and REMU, one quotient bit per clock.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   request pulse, sampled only while idle
//   op         in   00=DIV 01=DIVU 10=REM 11=REMU
//   A, B       in   dividend / divisor, captured with start
//   Result     out  quotient or remainder, held until the next done
//   busy       out  operation in flight
//   done       out  one-cycle pulse, Result and flags valid
//   DivByZero  out  zero divisor flag, held until the next done
//   OverFlow   out  signed overflow flag (MIN / -1), held until the next done
// Option:
//   RISCV_DIV_EARLY_OUT_EN - when defined, zero-divisor and signed-overflow
//   operations bypass the iteration phase and complete 2 edges after start.
//   When undefined, every operation takes WIDTH+2 edges.
// ============================================================================
module riscv_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             busy,
  output logic             done,
  output logic             DivByZero,
  output logic             OverFlow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] quo_q, quo_d;      // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder
  logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor magnitude
  logic [WIDTH-1:0] a_q, a_d;          // raw dividend for the special-case overrides
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;
  logic             fix_ph_q, fix_ph_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dzf_q, dzf_d;
  logic             ovf_q, ovf_d;

  logic             w_signed;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_dz;
  logic             w_ov;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  assign w_signed = ~op[0];
  // Most-negative dividend negates to itself, which is the correct magnitude
  // when read as unsigned.
  assign w_a_abs  = (w_signed && A[WIDTH-1]) ? -A : A;
  assign w_b_abs  = (w_signed && B[WIDTH-1]) ? -B : B;
  assign w_dz     = (B == '0);
  assign w_ov     = w_signed && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (&B);

  // Trial subtraction on WIDTH+1 bits: the borrow (MSB) decides restore.
  assign w_shift  = {rem_q, quo_q[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, dvs_q};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    a_d      = a_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    ov_d     = ov_q;
    fix_ph_d = fix_ph_q;
    res_d    = res_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dzf_d    = dzf_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op;
          quo_d    = w_a_abs;
          dvs_d    = w_b_abs;
          a_d      = A;
          rem_d    = '0;
          cnt_d    = CW'(WIDTH);
          qneg_d   = w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          rneg_d   = w_signed & A[WIDTH-1];
          dz_d     = w_dz;
          ov_d     = w_ov & ~w_dz;
          fix_ph_d = 1'b0;
          busy_d   = 1'b1;
`ifdef RISCV_DIV_EARLY_OUT_EN
          state_d  = (w_dz || w_ov) ? S_FIX : S_ITER;
`else
          state_d  = S_ITER;
`endif
        end
      end

      S_ITER: begin
        quo_d = {quo_q[WIDTH-2:0], ~w_diff[WIDTH]};
        rem_d = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        // Two phases: sign correction is registered first so the negators
        // and the result/override mux sit on separate clock paths.
        if (!fix_ph_q) begin
          quo_d    = qneg_q ? -quo_q : quo_q;
          rem_d    = rneg_q ? -rem_q : rem_q;
          fix_ph_d = 1'b1;
        end else begin
          if (dz_q) begin
            res_d = op_q[1] ? a_q : '1;
          end else if (ov_q) begin
            res_d = op_q[1] ? '0 : a_q;
          end else begin
            res_d = op_q[1] ? rem_q : quo_q;
          end
          dzf_d    = dz_q;
          ovf_d    = ov_q;
          fix_ph_d = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      a_q      <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      ov_q     <= 1'b0;
      fix_ph_q <= 1'b0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dzf_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      a_q      <= a_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      ov_q     <= ov_d;
      fix_ph_q <= fix_ph_d;
      res_q    <= res_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dzf_q    <= dzf_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Result    = res_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign DivByZero = dzf_q;
  assign OverFlow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_div_unit
// Purpose  : Self-checking bench for riscv_div_unit: directed cases plus
//            randomized operations against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_div_unit;

`ifdef RISCV_DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Result;
  logic        busy;
  logic        done;
  logic        DivByZero;
  logic        OverFlow;

  int          total;
  int          bad;
  logic [1:0]  exp_op;
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic [31:0] last_res;

  riscv_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .A         (A),
    .B         (B),
    .Result    (Result),
    .busy      (busy),
    .done      (done),
    .DivByZero (DivByZero),
    .OverFlow  (OverFlow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: RISC-V division semantics with plain arithmetic.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic dz, output logic ov);
    dz = (b == 32'h0);
    ov = !o[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (dz)      r = o[1] ? a : 32'hFFFF_FFFF;
    else if (ov) r = o[1] ? 32'h0 : a;
    else begin
      case (o)
        2'd0:    r = $signed(a) / $signed(b);
        2'd1:    r = a / b;
        2'd2:    r = $signed(a) % $signed(b);
        default: r = a % b;
      endcase
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    A      = a;
    B      = b;
    exp_op = o;
    exp_a  = a;
    exp_b  = b;
  endtask

  // Waits for done after an issued start; poke_at >= 0 pulses a stray start
  // with random operands that edge count into the operation.
  task automatic finish_op(input string tag, input int poke_at);
    int          n;
    bit          busy_ok;
    logic [31:0] er;
    logic        edz;
    logic        eov;
    int          el;
    model(exp_op, exp_a, exp_b, er, edz, eov);
    el = ((edz || eov) && EARLY) ? 2 : 34;
    @(posedge clk); #1;
    start = 1'b0;
    A  = $urandom;
    B  = $urandom;
    op = 2'($urandom_range(0, 3));
    n = 0;
    busy_ok = (busy === 1'b1);
    while (done !== 1'b1 && n < 100) begin
      if (n == poke_at) begin
        start = 1'b1;
        A = $urandom;
        B = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'(el));
    chk({tag, "_busy_held"}, {31'h0, busy_ok}, 32'h1);
    chk({tag, "_busy_at_done"}, {31'h0, busy}, 32'h0);
    chk({tag, "_result"}, Result, er);
    chk({tag, "_divbyzero"}, {31'h0, DivByZero}, {31'h0, edz});
    chk({tag, "_overflow"}, {31'h0, OverFlow}, {31'h0, eov});
    last_res = er;
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    issue(o, a, b);
    finish_op(tag, -1);
  endtask

  initial begin
    bit seen_done;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    start = 1'b1;
    op    = 2'd1;
    A     = 32'd5;
    B     = 32'd1;
    last_res = 32'h0;

    // Reset held with start asserted: everything stays quiet.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", Result, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_flags", {30'h0, DivByZero, OverFlow}, 32'h0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_quiet", {30'h0, busy, done}, 32'h0);
    chk("idle_result", Result, 32'h0);

    // Unsigned basics.
    do_op("divu", 2'd1, 32'd100, 32'd7);
    chk("divu_const", Result, 32'd14);
    do_op("remu", 2'd3, 32'd100, 32'd7);
    chk("remu_const", Result, 32'd2);

    // Signed: remainder takes the dividend's sign.
    do_op("div_s", 2'd0, 32'hFFFF_FFF9, 32'd2);
    chk("div_s_const", Result, 32'hFFFF_FFFD);
    do_op("rem_s", 2'd2, 32'hFFFF_FFF9, 32'd2);
    chk("rem_s_const", Result, 32'hFFFF_FFFF);

    // Divide by zero.
    do_op("div0", 2'd0, 32'h1234_5678, 32'h0);
    chk("div0_const", Result, 32'hFFFF_FFFF);
    do_op("rem0", 2'd2, 32'h1234_5678, 32'h0);
    chk("rem0_const", Result, 32'h1234_5678);
    do_op("remu0", 2'd3, 32'h1234_5678, 32'h0);

    // Signed overflow and its unsigned counterpart.
    do_op("ovf_div", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_div_const", Result, 32'h8000_0000);
    do_op("ovf_rem", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_rem_const", Result, 32'h0);
    do_op("ovf_divu", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_divu_const", Result, 32'h0);

    // Stray start mid-operation is ignored.
    @(negedge clk);
    issue(2'd1, 32'd100, 32'd7);
    finish_op("poke", 5);
    chk("poke_const", Result, 32'd14);

    // Back-to-back: second start issued in the done cycle.
    do_op("b2b_first", 2'd3, 32'd100, 32'd7);
    issue(2'd0, 32'hFFFF_FFF9, 32'd2);
    finish_op("b2b_second", -1);
    chk("b2b_const", Result, 32'hFFFF_FFFD);

    // Reset asserted at iteration 10 aborts the operation.
    @(negedge clk);
    issue(2'd1, 32'd1000, 32'd3);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_result", Result, 32'h0);
    chk("abort_flags", {30'h0, DivByZero, OverFlow}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    chk("abort_no_done", {31'h0, seen_done}, 32'h0);

    // Randomized operations, biased toward the special operand pairs.
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      int          sel;
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0) rb = 32'h0;
      else if (sel == 1) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end else if (sel == 2) rb = 32'($urandom_range(1, 15));
      else if (sel == 3) rb = {16'hFFFF, 16'($urandom)};
      do_op("rnd", ro, ra, rb);
      @(posedge clk); #1;
      chk("rnd_done_pulse", {31'h0, done}, 32'h0);
      chk("rnd_result_hold", Result, last_res);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
